// File: rtl/ysyx_22040750_npc_gen.sv
// ==========================================================================
// Module   : ysyx_22040750_npc_gen
// Purpose  : Next-PC generator. Fixed-priority redirect arbiter with a
//            one-entry pending register, feeding the PC register through a
//            valid/ready handshake. Optional macro
//            YSYX_22040750_NPC_MISALIGN_EN adds the O_misalign output.
// Revision : 1.0 - initial release
// ==========================================================================
`default_nettype none

module ysyx_22040750_npc_gen #(
    parameter int              XLEN   = 32,
    parameter int              NSRC   = 4,
    parameter logic [XLEN-1:0] RST_PC = 'h8000_0000,
    parameter int              ILEN   = 4
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic [NSRC-1:0]      I_redir_valid,
    input  logic [NSRC*XLEN-1:0] I_redir_base,
    input  logic [NSRC*XLEN-1:0] I_redir_off,
    input  logic [NSRC-1:0]      I_redir_clr_lsb,
    input  logic                 I_pc_ready,
    input  logic                 I_halt,
    output logic                 O_pc_valid,
    output logic [XLEN-1:0]      O_pc,
    output logic                 O_pend
`ifdef YSYX_22040750_NPC_MISALIGN_EN
    ,
    output logic                 O_misalign
`endif
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(NSRC - 1);

    typedef enum logic [0:0] {
        ST_SEQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] seq_pc_q, seq_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [IDXW-1:0] pend_idx_q, pend_idx_d;

    logic [NSRC-1:0][XLEN-1:0] w_tgt;
    logic [IDXW-1:0]           w_win_idx;
    logic [XLEN-1:0]           w_win_t;
    logic                      w_any;
    logic                      w_preempt;
    logic                      w_pc_valid;
    logic [XLEN-1:0]           w_pc;
    logic                      w_hs;

    // Per-channel target; carry out of the add is dropped on purpose.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_tgt
            logic [XLEN-1:0] w_sum;
            assign w_sum = I_redir_base[gi*XLEN +: XLEN] + I_redir_off[gi*XLEN +: XLEN];
            assign w_tgt[gi] = {w_sum[XLEN-1:1], w_sum[0] & ~I_redir_clr_lsb[gi]};
        end
    endgenerate

    // Scan from the lowest priority upward so the lowest valid index wins.
    always_comb begin
        w_win_idx = c_IDX_LAST;
        w_win_t   = w_tgt[NSRC-1];
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (I_redir_valid[i]) begin
                w_win_idx = IDXW'(i);
                w_win_t   = w_tgt[i];
            end
        end
    end

    assign w_any     = |I_redir_valid;
    assign w_preempt = (state_q == ST_HOLD) && w_any && (w_win_idx < pend_idx_q);

    always_comb begin
        w_pc       = seq_pc_q;
        w_pc_valid = 1'b0;
        if (I_rst) begin
            w_pc       = RST_PC;
            w_pc_valid = 1'b0;
        end else begin
            if (state_q == ST_HOLD) begin
                w_pc = w_preempt ? w_win_t : pend_pc_q;
            end else if (w_any) begin
                w_pc = w_win_t;
            end
            w_pc_valid = (w_any || (state_q == ST_HOLD)) ? 1'b1 : ~I_halt;
        end
    end

    assign w_hs = w_pc_valid & I_pc_ready;

    always_comb begin
        state_d    = state_q;
        seq_pc_d   = seq_pc_q;
        pend_pc_d  = pend_pc_q;
        pend_idx_d = pend_idx_q;
        if (w_hs) begin
            seq_pc_d = w_pc + XLEN'(ILEN);
        end
        case (state_q)
            ST_SEQ: begin
                if (w_any && !w_hs) begin
                    state_d    = ST_HOLD;
                    pend_pc_d  = w_win_t;
                    pend_idx_d = w_win_idx;
                end
            end
            ST_HOLD: begin
                // A still-asserted redirect that did not preempt is consumed by the handshake.
                if (w_hs) begin
                    state_d    = ST_SEQ;
                    pend_pc_d  = '0;
                    pend_idx_d = c_IDX_LAST;
                end else if (w_preempt) begin
                    pend_pc_d  = w_win_t;
                    pend_idx_d = w_win_idx;
                end
            end
            default: state_d = ST_SEQ;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= ST_SEQ;
            seq_pc_q   <= RST_PC;
            pend_pc_q  <= '0;
            pend_idx_q <= c_IDX_LAST;
        end else begin
            state_q    <= state_d;
            seq_pc_q   <= seq_pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    assign O_pc_valid = w_pc_valid;
    assign O_pc       = w_pc;
    assign O_pend     = (state_q == ST_HOLD) & ~I_rst;

`ifdef YSYX_22040750_NPC_MISALIGN_EN
    assign O_misalign = w_pc_valid & (w_pc[1:0] != 2'b00);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040750_npc_gen.sv
// ==========================================================================
// Module   : tb_ysyx_22040750_npc_gen
// Purpose  : Directed, table-driven bench for ysyx_22040750_npc_gen.
// Revision : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_ysyx_22040750_npc_gen;

    localparam int XLEN = 32;
    localparam int NSRC = 4;

    typedef struct {
        logic                      rst;
        logic                      ready;
        logic                      halt;
        logic [3:0]                valid;
        logic [3:0]                clr;
        logic [3:0][31:0]          base;
        logic [3:0][31:0]          off;
        logic                      e_valid;
        logic [31:0]               e_pc;
        logic                      e_pend;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NSRC-1:0]      redir_valid;
    logic [NSRC*XLEN-1:0] redir_base;
    logic [NSRC*XLEN-1:0] redir_off;
    logic [NSRC-1:0]      redir_clr;
    logic                 pc_ready;
    logic                 halt;
    logic                 pc_valid;
    logic [XLEN-1:0]      pc;
    logic                 pend;
`ifdef YSYX_22040750_NPC_MISALIGN_EN
    logic                 misalign;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    ysyx_22040750_npc_gen dut (
        .I_clk           (clk),
        .I_rst           (rst),
        .I_redir_valid   (redir_valid),
        .I_redir_base    (redir_base),
        .I_redir_off     (redir_off),
        .I_redir_clr_lsb (redir_clr),
        .I_pc_ready      (pc_ready),
        .I_halt          (halt),
        .O_pc_valid      (pc_valid),
        .O_pc            (pc),
        .O_pend          (pend)
`ifdef YSYX_22040750_NPC_MISALIGN_EN
        ,
        .O_misalign      (misalign)
`endif
    );

    function automatic vec_t mk(input logic r, input logic rdy, input logic h,
                                input logic [3:0] v, input logic [3:0] c,
                                input logic [127:0] b, input logic [127:0] o,
                                input logic ev, input logic [31:0] epc, input logic ep);
        vec_t t;
        t.rst = r; t.ready = rdy; t.halt = h; t.valid = v; t.clr = c;
        t.base = b; t.off = o; t.e_valid = ev; t.e_pc = epc; t.e_pend = ep;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic apply(input vec_t t, input int idx);
        @(posedge clk);
        #1;
        rst = t.rst; pc_ready = t.ready; halt = t.halt;
        redir_valid = t.valid; redir_clr = t.clr;
        redir_base = t.base; redir_off = t.off;
        @(negedge clk);
        chk("pc_valid", idx, 32'(pc_valid), 32'(t.e_valid));
        chk("pc", idx, pc, t.e_pc);
        chk("pend", idx, 32'(pend), 32'(t.e_pend));
`ifdef YSYX_22040750_NPC_MISALIGN_EN
        chk("misalign", idx, 32'(misalign), 32'(t.e_valid && (t.e_pc[1:0] != 2'b00)));
`endif
    endtask

    localparam logic [127:0] Z = '0;

    initial begin
        rst = 1'b1; pc_ready = 1'b0; halt = 1'b0;
        redir_valid = '0; redir_clr = '0; redir_base = '0; redir_off = '0;

        // reset, then sequential issue
        tbl.push_back(mk(1,1,0,4'b0000,4'b0000,Z,Z, 0,32'h8000_0000,0));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0000,0));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0004,0));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0008,0));
        // channel 2 redirect held across 3 stall cycles
        tbl.push_back(mk(0,0,0,4'b0100,4'b0000,{32'h0,32'h8000_0010,64'h0},{32'h0,32'h20,64'h0}, 1,32'h8000_0030,0));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0030,1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0030,1));
        tbl.push_back(mk(0,0,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0030,1));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0030,1));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0034,0));
        // channel 3 pending, channel 0 overrides, later channel 3 ignored, halt in HOLD
        tbl.push_back(mk(0,0,0,4'b1000,4'b0000,{32'h8000_0100,96'h0},Z, 1,32'h8000_0100,0));
        tbl.push_back(mk(0,0,0,4'b0001,4'b0000,{96'h0,32'h8000_0200},Z, 1,32'h8000_0200,1));
        tbl.push_back(mk(0,0,0,4'b1000,4'b0000,{32'h8000_0400,96'h0},Z, 1,32'h8000_0200,1));
        tbl.push_back(mk(0,0,1,4'b0000,4'b0000,Z,Z, 1,32'h8000_0200,1));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0200,1));
        // halt in SEQ with no redirect
        tbl.push_back(mk(0,0,1,4'b0000,4'b0000,Z,Z, 0,32'h8000_0204,0));
        // JALR with LSB clear, accepted the same cycle
        tbl.push_back(mk(0,1,0,4'b0010,4'b0010,{64'h0,32'h8000_0003,32'h0},Z, 1,32'h8000_0002,0));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0006,0));
        // simultaneous channels 1 and 2; equal and lower priority ignored while held
        tbl.push_back(mk(0,0,0,4'b0110,4'b0000,{32'h0,32'h8000_0600,32'h8000_0500,32'h0},{64'h0,32'h8,32'h0}, 1,32'h8000_0508,0));
        tbl.push_back(mk(0,0,0,4'b0010,4'b0000,{64'h0,32'h8000_0700,32'h0},Z, 1,32'h8000_0508,1));
        tbl.push_back(mk(0,1,0,4'b0100,4'b0000,{32'h0,32'h8000_0800,64'h0},Z, 1,32'h8000_0508,1));
        tbl.push_back(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_050C,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // sequence: seq_pc wraps past FFFF_FFFC, then target add wraps
        apply(mk(0,1,0,4'b0001,4'b0000,{96'h0,32'hFFFF_FFF8},{96'h0,32'h4}, 1,32'hFFFF_FFFC,0), 100);
        apply(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h0000_0000,0), 101);
        apply(mk(0,1,0,4'b0001,4'b0000,{96'h0,32'hFFFF_FFF0},{96'h0,32'h20}, 1,32'h0000_0010,0), 102);
        apply(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h0000_0014,0), 103);

        // sequence: reset while HOLD discards the pending redirect
        apply(mk(0,0,0,4'b0100,4'b0000,{32'h0,32'h8000_0300,64'h0},Z, 1,32'h8000_0300,0), 200);
        apply(mk(0,0,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0300,1), 201);
        apply(mk(1,0,0,4'b0001,4'b0000,{96'h0,32'h0000_1234},Z, 0,32'h8000_0000,0), 202);
        apply(mk(0,0,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0000,0), 203);
        apply(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0000,0), 204);
        apply(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0004,0), 205);

        // sequence: halt right after reset release
        apply(mk(1,1,1,4'b0000,4'b0000,Z,Z, 0,32'h8000_0000,0), 300);
        apply(mk(0,1,1,4'b0000,4'b0000,Z,Z, 0,32'h8000_0000,0), 301);
        apply(mk(0,1,0,4'b0000,4'b0000,Z,Z, 1,32'h8000_0000,0), 302);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
